init_command_sequencer_8259: RTL and testbench
==============================================

INIT_COMMAND_SEQUENCER_8259 -- requirements
Module: init_command_sequencer_8259

Interface
Parameters: none.
REQ-001 The module SHALL have these ports, one per line: name  direction  width  meaning.
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- internal_data_bus  in  8  latched data byte from the bus-control stage.
- write_icw1  in  1  1-cycle strobe: ICW1 byte on internal_data_bus.
- write_icw2_4  in  1  1-cycle strobe: A0=1 write (ICW2/3/4 during init).
- write_ocw1  in  1  1-cycle strobe: A0=1 write (OCW1 when initialised).
- write_ocw2  in  1  1-cycle strobe: OCW2 byte.
- write_ocw3  in  1  1-cycle strobe: OCW3 byte.
- init_done  out  1  high in READY state.
- level_triggered  out  1  ICW1.LTIM.
- single_mode  out  1  ICW1.SNGL.
- vector_base  out  5  ICW2[7:3].
- cascade_config  out  8  ICW3 byte.
- u8086_mode / auto_eoi / buffered_mode / buffered_master / special_fully_nested  out  1 each  ICW4 bits 0/1/3/2/4.
- interrupt_mask  out  8  IMR (OCW1).
- auto_rotate  out  1  rotate-in-AEOI mode.
- eoi_nonspecific  out  1  1-cycle pulse.
- eoi_specific  out  1  1-cycle pulse; level on eoi_level.
- eoi_level  out  3  OCW2[2:0], valid with any OCW2 pulse.
- rotate_on_eoi  out  1  1-cycle pulse, qualifies the concurrent EOI pulse.
- set_priority  out  1  1-cycle pulse; eoi_level = new lowest-priority IR.
- priority_reset  out  1  1-cycle pulse on ICW1 (IR7 becomes lowest).
- read_isr_select  out  1  0 = IRR on read, 1 = ISR.
- special_mask_mode  out  1  SMM flag.
- poll_command  out  1  1-cycle pulse on OCW3 with P=1.
REQ-002 Clock and reset SHALL be exactly one clock, synchronous active-high reset, as named above.

Function
REQ-003 States SHALL be WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY; init_done=1 only in READY.
REQ-004 write_icw1 in any state SHALL latch LTIM(bit3), SNGL(bit1), IC4(bit0), go to WAIT_ICW2 next cycle, and in the same cycle clear interrupt_mask, special_mask_mode, auto_rotate, read_isr_select, pulse priority_reset.
REQ-005 write_icw1 with IC4=0 SHALL clear all five ICW4 outputs.
REQ-006 WAIT_ICW2 + write_icw2_4: latch vector_base = data[7:3]; next = WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-007 WAIT_ICW3 + write_icw2_4: latch cascade_config; next = WAIT_ICW4 if IC4=1, else READY.
REQ-008 WAIT_ICW4 + write_icw2_4: latch ICW4 bits per REQ-001; next = READY.
REQ-009 write_icw2_4 SHALL be ignored in WAIT_ICW1 and READY; write_ocw1/2/3 SHALL be ignored in every state except READY.
REQ-010 READY + write_ocw1: interrupt_mask = data, visible next cycle.
REQ-011 READY + write_ocw2, decode data[7:5] (R,SL,EOI): 001 eoi_nonspecific; 011 eoi_specific; 101 eoi_nonspecific+rotate_on_eoi; 111 eoi_specific+rotate_on_eoi; 110 set_priority; 100 auto_rotate<=1; 000 auto_rotate<=0; 010 no action.
REQ-012 READY + write_ocw3 (data[7]=0): data[1:0]=10 -> read_isr_select<=0; 11 -> 1; 0x unchanged; data[6]=1 -> special_mask_mode<=data[5]; data[2]=1 -> pulse poll_command.
REQ-013 All pulse outputs SHALL be registered, asserted exactly the cycle after the strobe, for one cycle; eoi_level registered with them.
REQ-014 Simultaneous strobes: write_icw1 SHALL take priority and all others that cycle be discarded; in READY, write_icw2_4 concurrent with write_ocw1 SHALL act as OCW1 only.
REQ-015 ICW1 mid-sequence SHALL restart at WAIT_ICW2 with no retention of partial ICW2-4 progress (previous latched values held until overwritten).

Reset
REQ-016 reset SHALL force WAIT_ICW1 and drive all outputs and registers to 0, overriding any strobe in the same cycle.

Verification
REQ-017 ICW1=0x13, ICW2=0x48, ICW4=0x03 -> vector_base=5'h09, auto_eoi=1, u8086_mode=1, init_done=1 after third write; no WAIT_ICW3.
REQ-018 ICW1=0x10 (cascade, no IC4), ICW2=0x20, ICW3=0x04 -> cascade_config=0x04, ICW4 outputs 0, init_done=1.
REQ-019 READY: OCW1=0xA5 -> interrupt_mask=0xA5; then ICW1=0x13 -> interrupt_mask=0x00, priority_reset one-cycle pulse, init_done=0.
REQ-020 READY: OCW2=0x63 -> eoi_specific pulse, eoi_level=3; OCW2=0xA0 -> eoi_nonspecific+rotate_on_eoi same cycle; OCW2=0x80 -> auto_rotate=1.
REQ-021 READY: OCW3=0x0B -> read_isr_select=1; OCW3=0x68 -> special_mask_mode=1; OCW3=0x0C -> poll_command pulse, read_isr_select unchanged.
REQ-022 OCW1 during WAIT_ICW2 ignored; reset asserted with write_ocw1 in READY -> all outputs 0, state WAIT_ICW1.

Source files
------------

// File: rtl/init_command_sequencer_8259.sv
// 8259-style initialisation and operation command sequencer: walks ICW1..ICW4,
// then decodes OCW1/OCW2/OCW3 into registered configuration levels and one-cycle pulses.
module init_command_sequencer_8259 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       write_icw1,
    input  logic       write_icw2_4,
    input  logic       write_ocw1,
    input  logic       write_ocw2,
    input  logic       write_ocw3,
    output logic       init_done,
    output logic       level_triggered,
    output logic       single_mode,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       u8086_mode,
    output logic       auto_eoi,
    output logic       buffered_mode,
    output logic       buffered_master,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       auto_rotate,
    output logic       eoi_nonspecific,
    output logic       eoi_specific,
    output logic [2:0] eoi_level,
    output logic       rotate_on_eoi,
    output logic       set_priority,
    output logic       priority_reset,
    output logic       read_isr_select,
    output logic       special_mask_mode,
    output logic       poll_command
);

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t state;
    state_t next_state;
    logic   icw4_needed;

    always_ff @(posedge clock) begin
        if (reset) state <= WAIT_ICW1;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (write_icw1) begin
            next_state = WAIT_ICW2;
        end else if (write_icw2_4) begin
            case (state)
                WAIT_ICW2: begin
                    if (!single_mode)     next_state = WAIT_ICW3;
                    else if (icw4_needed) next_state = WAIT_ICW4;
                    else                  next_state = READY;
                end
                WAIT_ICW3: next_state = icw4_needed ? WAIT_ICW4 : READY;
                WAIT_ICW4: next_state = READY;
                default:   next_state = state;
            endcase
        end
    end

    assign init_done = (state == READY);

    always_ff @(posedge clock) begin
        if (reset) begin
            level_triggered      <= 1'b0;
            single_mode          <= 1'b0;
            icw4_needed          <= 1'b0;
            vector_base          <= '0;
            cascade_config       <= '0;
            u8086_mode           <= 1'b0;
            auto_eoi             <= 1'b0;
            buffered_mode        <= 1'b0;
            buffered_master      <= 1'b0;
            special_fully_nested <= 1'b0;
            interrupt_mask       <= '0;
            auto_rotate          <= 1'b0;
            eoi_nonspecific      <= 1'b0;
            eoi_specific         <= 1'b0;
            eoi_level            <= '0;
            rotate_on_eoi        <= 1'b0;
            set_priority         <= 1'b0;
            priority_reset       <= 1'b0;
            read_isr_select      <= 1'b0;
            special_mask_mode    <= 1'b0;
            poll_command         <= 1'b0;
        end else begin
            eoi_nonspecific <= 1'b0;
            eoi_specific    <= 1'b0;
            rotate_on_eoi   <= 1'b0;
            set_priority    <= 1'b0;
            priority_reset  <= 1'b0;
            poll_command    <= 1'b0;

            // ICW1 wins over every other strobe in the same cycle
            if (write_icw1) begin
                level_triggered   <= internal_data_bus[3];
                single_mode       <= internal_data_bus[1];
                icw4_needed       <= internal_data_bus[0];
                interrupt_mask    <= '0;
                special_mask_mode <= 1'b0;
                auto_rotate       <= 1'b0;
                read_isr_select   <= 1'b0;
                priority_reset    <= 1'b1;
                if (!internal_data_bus[0]) begin
                    u8086_mode           <= 1'b0;
                    auto_eoi             <= 1'b0;
                    buffered_mode        <= 1'b0;
                    buffered_master      <= 1'b0;
                    special_fully_nested <= 1'b0;
                end
            end else begin
                if (write_icw2_4) begin
                    case (state)
                        WAIT_ICW2: vector_base    <= internal_data_bus[7:3];
                        WAIT_ICW3: cascade_config <= internal_data_bus;
                        WAIT_ICW4: begin
                            u8086_mode           <= internal_data_bus[0];
                            auto_eoi             <= internal_data_bus[1];
                            buffered_master      <= internal_data_bus[2];
                            buffered_mode        <= internal_data_bus[3];
                            special_fully_nested <= internal_data_bus[4];
                        end
                        default: ;
                    endcase
                end

                if (state == READY) begin
                    if (write_ocw1) interrupt_mask <= internal_data_bus;

                    if (write_ocw2) begin
                        eoi_level <= internal_data_bus[2:0];
                        case (internal_data_bus[7:5])
                            3'b001: eoi_nonspecific <= 1'b1;
                            3'b011: eoi_specific    <= 1'b1;
                            3'b101: begin
                                eoi_nonspecific <= 1'b1;
                                rotate_on_eoi   <= 1'b1;
                            end
                            3'b111: begin
                                eoi_specific  <= 1'b1;
                                rotate_on_eoi <= 1'b1;
                            end
                            3'b110: set_priority <= 1'b1;
                            3'b100: auto_rotate  <= 1'b1;
                            3'b000: auto_rotate  <= 1'b0;
                            default: ;
                        endcase
                    end

                    if (write_ocw3 && !internal_data_bus[7]) begin
                        if (internal_data_bus[1]) read_isr_select   <= internal_data_bus[0];
                        if (internal_data_bus[6]) special_mask_mode <= internal_data_bus[5];
                        if (internal_data_bus[2]) poll_command      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_init_command_sequencer_8259.sv
// Randomised bench for init_command_sequencer_8259: a queue-based model of the
// pending ICW steps predicts every output after each clock.
module tb_init_command_sequencer_8259;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] internal_data_bus;
    logic       write_icw1, write_icw2_4, write_ocw1, write_ocw2, write_ocw3;
    logic       init_done, level_triggered, single_mode;
    logic [4:0] vector_base;
    logic [7:0] cascade_config;
    logic       u8086_mode, auto_eoi, buffered_mode, buffered_master, special_fully_nested;
    logic [7:0] interrupt_mask;
    logic       auto_rotate, eoi_nonspecific, eoi_specific, rotate_on_eoi;
    logic [2:0] eoi_level;
    logic       set_priority, priority_reset, read_isr_select, special_mask_mode, poll_command;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    init_command_sequencer_8259 dut (
        .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
        .write_icw1(write_icw1), .write_icw2_4(write_icw2_4), .write_ocw1(write_ocw1),
        .write_ocw2(write_ocw2), .write_ocw3(write_ocw3),
        .init_done(init_done), .level_triggered(level_triggered), .single_mode(single_mode),
        .vector_base(vector_base), .cascade_config(cascade_config),
        .u8086_mode(u8086_mode), .auto_eoi(auto_eoi), .buffered_mode(buffered_mode),
        .buffered_master(buffered_master), .special_fully_nested(special_fully_nested),
        .interrupt_mask(interrupt_mask), .auto_rotate(auto_rotate),
        .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .rotate_on_eoi(rotate_on_eoi), .set_priority(set_priority),
        .priority_reset(priority_reset), .read_isr_select(read_isr_select),
        .special_mask_mode(special_mask_mode), .poll_command(poll_command)
    );

    always #5 clock = ~clock;

    // Reference model: pending ICW numbers still owed in the current init sequence
    int         m_pending[$];
    logic       m_ready, m_ltim, m_sngl, m_ic4;
    logic [4:0] m_vb;
    logic [7:0] m_cas, m_mask;
    logic       m_8086, m_aeoi, m_buf, m_bufm, m_sfnm;
    logic       m_arot, m_nseoi, m_seoi, m_rot, m_setp, m_prst, m_risr, m_smm, m_poll;
    logic [2:0] m_lvl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_update(input logic rst, input logic i1, input logic i24,
                                input logic o1, input logic o2, input logic o3,
                                input logic [7:0] d);
        logic was_ready;
        int   step;
        was_ready = m_ready;
        {m_nseoi, m_seoi, m_rot, m_setp, m_prst, m_poll} = '0;
        if (rst) begin
            m_pending.delete();
            m_ready = 0; m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_vb = 0; m_cas = 0;
            m_8086 = 0; m_aeoi = 0; m_buf = 0; m_bufm = 0; m_sfnm = 0;
            m_mask = 0; m_arot = 0; m_risr = 0; m_smm = 0; m_lvl = 0;
        end else if (i1) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_mask = 0; m_smm = 0; m_arot = 0; m_risr = 0; m_prst = 1;
            if (!m_ic4) {m_8086, m_aeoi, m_buf, m_bufm, m_sfnm} = '0;
            m_pending.delete();
            m_pending.push_back(2);
            if (!m_sngl) m_pending.push_back(3);
            if (m_ic4)   m_pending.push_back(4);
            m_ready = 0;
        end else begin
            if (i24 && m_pending.size() > 0) begin
                step = m_pending.pop_front();
                if (step == 2)      m_vb  = 5'(d / 8);
                else if (step == 3) m_cas = d;
                else begin
                    m_8086 = d[0]; m_aeoi = d[1]; m_bufm = d[2]; m_buf = d[3]; m_sfnm = d[4];
                end
                if (m_pending.size() == 0) m_ready = 1;
            end
            if (was_ready) begin
                if (o1) m_mask = d;
                if (o2) begin
                    m_lvl = 3'(d % 8);
                    if (d[5]) begin
                        if (d[6]) m_seoi = 1; else m_nseoi = 1;
                        m_rot = d[7];
                    end else if (d[7]) begin
                        if (d[6]) m_setp = 1; else m_arot = 1;
                    end else if (!d[6]) begin
                        m_arot = 0;
                    end
                end
                if (o3 && d < 8'h80) begin
                    if ((d & 8'h03) == 8'h02) m_risr = 0;
                    if ((d & 8'h03) == 8'h03) m_risr = 1;
                    if (d[6]) m_smm = d[5];
                    if (d[2]) m_poll = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("init_done", init_done, m_ready);
        check("level_triggered", level_triggered, m_ltim);
        check("single_mode", single_mode, m_sngl);
        check("vector_base", vector_base, m_vb);
        check("cascade_config", cascade_config, m_cas);
        check("u8086_mode", u8086_mode, m_8086);
        check("auto_eoi", auto_eoi, m_aeoi);
        check("buffered_mode", buffered_mode, m_buf);
        check("buffered_master", buffered_master, m_bufm);
        check("special_fully_nested", special_fully_nested, m_sfnm);
        check("interrupt_mask", interrupt_mask, m_mask);
        check("auto_rotate", auto_rotate, m_arot);
        check("eoi_nonspecific", eoi_nonspecific, m_nseoi);
        check("eoi_specific", eoi_specific, m_seoi);
        check("rotate_on_eoi", rotate_on_eoi, m_rot);
        check("set_priority", set_priority, m_setp);
        check("priority_reset", priority_reset, m_prst);
        check("read_isr_select", read_isr_select, m_risr);
        check("special_mask_mode", special_mask_mode, m_smm);
        check("poll_command", poll_command, m_poll);
        if (m_nseoi || m_seoi || m_setp) check("eoi_level", eoi_level, m_lvl);
    endtask

    task automatic cycle(input logic rst, input logic i1, input logic i24, input logic o1,
                         input logic o2, input logic o3, input logic [7:0] d);
        reset = rst; write_icw1 = i1; write_icw2_4 = i24;
        write_ocw1 = o1; write_ocw2 = o2; write_ocw3 = o3; internal_data_bus = d;
        @(posedge clock);
        model_update(rst, i1, i24, o1, o2, o3, d);
        #1;
        compare_all();
        reset = 0; {write_icw1, write_icw2_4, write_ocw1, write_ocw2, write_ocw3} = '0;
    endtask

    task automatic icw1(input logic [7:0] d);  cycle(0, 1, 0, 0, 0, 0, d); endtask
    task automatic icw24(input logic [7:0] d); cycle(0, 0, 1, 0, 0, 0, d); endtask
    task automatic ocw1(input logic [7:0] d);  cycle(0, 0, 0, 1, 0, 0, d); endtask
    task automatic ocw2(input logic [7:0] d);  cycle(0, 0, 0, 0, 1, 0, d); endtask
    task automatic ocw3(input logic [7:0] d);  cycle(0, 0, 0, 0, 0, 1, d); endtask
    task automatic idle();                     cycle(0, 0, 0, 0, 0, 0, 8'h00); endtask

    initial begin
        int unsigned r;
        logic [7:0]  d;
        logic [4:0]  extra;
        reset = 1; internal_data_bus = '0;
        {write_icw1, write_icw2_4, write_ocw1, write_ocw2, write_ocw3} = '0;
        cycle(1, 0, 0, 0, 0, 0, 8'h00);
        check("reset_init_done", init_done, 1'b0);
        cycle(1, 1, 1, 1, 1, 1, 8'hFF);
        check("reset_over_strobe", {interrupt_mask, priority_reset}, 9'h000);

        // single, with ICW4: no ICW3 step
        icw1(8'h13);
        icw24(8'h48);
        check("seq17_not_done", init_done, 1'b0);
        icw24(8'h03);
        check("seq17_done", init_done, 1'b1);
        check("seq17_vb", vector_base, 5'h09);
        check("seq17_icw4", {u8086_mode, auto_eoi}, 2'b11);

        // cascade, no ICW4
        icw1(8'h10);
        check("seq18_icw4_cleared", {u8086_mode, auto_eoi}, 2'b00);
        icw24(8'h20);
        icw24(8'h04);
        check("seq18_done", init_done, 1'b1);
        check("seq18_cas", cascade_config, 8'h04);
        icw24(8'hEE);
        check("icw24_ignored_ready", cascade_config, 8'h04);

        ocw1(8'hA5);
        check("ocw1_mask", interrupt_mask, 8'hA5);
        icw1(8'h13);
        check("icw1_mask_clr", interrupt_mask, 8'h00);
        check("icw1_prst", priority_reset, 1'b1);
        check("icw1_not_done", init_done, 1'b0);
        ocw1(8'hFF);
        check("prst_one_cycle", priority_reset, 1'b0);
        check("ocw1_ignored_wait", interrupt_mask, 8'h00);
        icw24(8'h48);
        icw24(8'h03);

        ocw2(8'h63);
        check("ocw2_seoi", {eoi_specific, eoi_level}, 4'b1_011);
        ocw2(8'hA0);
        check("ocw2_nseoi_rot", {eoi_nonspecific, rotate_on_eoi}, 2'b11);
        ocw2(8'h80);
        check("ocw2_arot", auto_rotate, 1'b1);
        ocw2(8'hC5);
        check("ocw2_setp", {set_priority, eoi_level}, 4'b1_101);

        ocw3(8'h0B);
        check("ocw3_risr", read_isr_select, 1'b1);
        ocw3(8'h68);
        check("ocw3_smm", special_mask_mode, 1'b1);
        ocw3(8'h0C);
        check("ocw3_poll", {poll_command, read_isr_select}, 2'b11);
        idle();

        cycle(0, 0, 1, 1, 0, 0, 8'h3C);
        check("icw24_with_ocw1", interrupt_mask, 8'h3C);
        cycle(0, 1, 1, 1, 1, 1, 8'h1B);
        check("icw1_priority", {interrupt_mask, eoi_nonspecific}, 9'h000);
        icw24(8'hF8);
        icw24(8'h1F);
        ocw1(8'h5A);
        cycle(1, 0, 0, 1, 0, 0, 8'hFF);
        check("reset_in_ready", {init_done, interrupt_mask, vector_base}, 14'h0);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            extra = 5'($urandom);
            if (r < 2)       cycle(1, extra[0], extra[1], extra[2], extra[3], extra[4], d);
            else if (r < 9)  cycle(0, 1, extra[1], extra[2], extra[3], extra[4], d);
            else if (r < 35) icw24(d);
            else if (r < 42) cycle(0, 0, 1, 1, 0, 0, d);
            else if (r < 55) ocw1(d);
            else if (r < 72) ocw2(d);
            else if (r < 88) ocw3(d);
            else if (r < 93) cycle(0, 0, extra[1], extra[2], extra[3], extra[4], d);
            else             idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
